// File: rtl/bram_pkg.sv
// Shared types and sizing helpers for the BRAM read arbiter.
package bram_pkg;

  localparam int unsigned NUM_RD_CLIENTS = 2;

  typedef logic client_id_t;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer updated on grant.
module rr_arbiter
  import bram_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_RD_CLIENTS-1:0] i_req,
  output logic [NUM_RD_CLIENTS-1:0] o_gnt
);

  client_id_t r_last;

  always_comb begin
    o_gnt = '0;
    if (i_req[0] && i_req[1]) o_gnt[~r_last] = 1'b1;
    else                      o_gnt = i_req;
  end

  // Reset to "client 1 granted last" so client 0 wins the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      r_last <= client_id_t'(1);
    else if (|o_gnt) r_last <= o_gnt[1];
  end

endmodule

// File: rtl/bram_arbiter.sv
// Two-client read arbiter in front of a single-port-read BRAM, with write pass-through.
module bram_arbiter
  import bram_pkg::*;
#(
  parameter  int unsigned BRAM_DATA_WIDTH = 8,
  parameter  int unsigned IMAGE_SIZE      = 388800,
  localparam int unsigned ADDR_WIDTH      = addr_width(IMAGE_SIZE)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       rd0_req,
  input  logic [ADDR_WIDTH-1:0]      rd0_addr,
  output logic                       rd0_gnt,
  output logic                       rd0_rvalid,
  output logic [BRAM_DATA_WIDTH-1:0] rd0_rdata,
  input  logic                       rd0_rready,
  input  logic                       rd1_req,
  input  logic [ADDR_WIDTH-1:0]      rd1_addr,
  output logic                       rd1_gnt,
  output logic                       rd1_rvalid,
  output logic [BRAM_DATA_WIDTH-1:0] rd1_rdata,
  input  logic                       rd1_rready,
  input  logic                       wr_req,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] wr_data,
  output logic                       wr_gnt,
  output logic [ADDR_WIDTH-1:0]      bram_rd_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_rd_data,
  output logic [ADDR_WIDTH-1:0]      bram_wr_addr,
  output logic [BRAM_DATA_WIDTH-1:0] bram_wr_data,
  output logic                       bram_wr_en,
  output logic                       busy
);

  logic [NUM_RD_CLIENTS-1:0] w_req;
  logic [NUM_RD_CLIENTS-1:0] w_rready;
  logic [NUM_RD_CLIENTS-1:0] w_elig;
  logic [NUM_RD_CLIENTS-1:0] w_gnt;
  logic [ADDR_WIDTH-1:0]     w_rd_addr;

  logic [NUM_RD_CLIENTS-1:0] r_rvalid;
  logic [BRAM_DATA_WIDTH-1:0] r_rdata [NUM_RD_CLIENTS];
  logic                      r_inflight;
  client_id_t                r_tag;
  logic [ADDR_WIDTH-1:0]     r_rd_addr;

  assign w_req    = {rd1_req, rd0_req};
  assign w_rready = {rd1_rready, rd0_rready};

  // Only one read can be outstanding at a time, so a single flag plus tag is enough.
  always_comb begin
    w_elig = '0;
    for (int unsigned n = 0; n < NUM_RD_CLIENTS; n++) begin
      w_elig[n] = reset && w_req[n]
                  && !(r_inflight && (r_tag == client_id_t'(n)))
                  && (!r_rvalid[n] || w_rready[n]);
    end
  end

  rr_arbiter u_rr (
    .clock (clock),
    .reset (reset),
    .i_req (w_elig),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_rd_addr = r_rd_addr;
    if (w_gnt[0])      w_rd_addr = rd0_addr;
    else if (w_gnt[1]) w_rd_addr = rd1_addr;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_inflight <= 1'b0;
      r_tag      <= '0;
      r_rd_addr  <= '0;
      r_rvalid   <= '0;
      for (int unsigned n = 0; n < NUM_RD_CLIENTS; n++) r_rdata[n] <= '0;
    end else begin
      r_inflight <= |w_gnt;
      r_rd_addr  <= w_rd_addr;
      if (|w_gnt) r_tag <= w_gnt[1];
      for (int unsigned n = 0; n < NUM_RD_CLIENTS; n++) begin
        if (r_inflight && (r_tag == client_id_t'(n))) begin
          r_rvalid[n] <= 1'b1;
          r_rdata[n]  <= bram_rd_data;
        end else if (w_rready[n]) begin
          r_rvalid[n] <= 1'b0;
        end
      end
    end
  end

  assign rd0_gnt      = w_gnt[0];
  assign rd1_gnt      = w_gnt[1];
  assign rd0_rvalid   = r_rvalid[0];
  assign rd1_rvalid   = r_rvalid[1];
  assign rd0_rdata    = r_rvalid[0] ? r_rdata[0] : '0;
  assign rd1_rdata    = r_rvalid[1] ? r_rdata[1] : '0;
  assign bram_rd_addr = w_rd_addr;

  assign wr_gnt       = wr_req;
  assign bram_wr_en   = wr_req;
  assign bram_wr_addr = wr_addr;
  assign bram_wr_data = wr_data;

  assign busy = r_inflight || (|r_rvalid);

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: behavioural BRAM, per-cycle scoreboard, literal spot checks.
module tb_bram_arbiter;

  localparam int unsigned IMG = 64;
  localparam int unsigned AW  = $clog2(IMG);
  localparam int unsigned DW  = 8;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd0_req = 1'b0, rd1_req = 1'b0;
  logic [AW-1:0] rd0_addr = '0, rd1_addr = '0;
  logic          rd0_rready = 1'b1, rd1_rready = 1'b1;
  logic          rd0_gnt, rd1_gnt, rd0_rvalid, rd1_rvalid;
  logic [DW-1:0] rd0_rdata, rd1_rdata;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_gnt, bram_wr_en, busy;
  logic [AW-1:0] bram_rd_addr, bram_wr_addr;
  logic [DW-1:0] bram_rd_data, bram_wr_data;

  int n_pass  = 0;
  int n_total = 0;

  bram_arbiter #(.BRAM_DATA_WIDTH(DW), .IMAGE_SIZE(IMG)) dut (
    .clock(clock), .reset(rst_n),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt),
    .rd0_rvalid(rd0_rvalid), .rd0_rdata(rd0_rdata), .rd0_rready(rd0_rready),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt),
    .rd1_rvalid(rd1_rvalid), .rd1_rdata(rd1_rdata), .rd1_rready(rd1_rready),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
    .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
    .bram_wr_en(bram_wr_en), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] init_val(input int unsigned a);
    return DW'(a * 7 + 3);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  // BRAM model: write lands before the registered read of the same edge.
  logic [DW-1:0] mem [IMG];
  initial begin
    for (int i = 0; i < int'(IMG); i++) mem[i] = init_val(i);
    mem[5] = 8'hA5;
    bram_rd_data = '0;
    forever begin
      @(posedge clock);
      if (bram_wr_en) mem[bram_wr_addr] = bram_wr_data;
      bram_rd_data <= mem[bram_rd_addr];
    end
  end

  // Scoreboard: each grant at cycle c produces data visible at cycle c+2.
  initial begin
    logic [DW-1:0] shadow [IMG];
    int            cyc;
    int            due [2];
    logic [DW-1:0] due_dat [2];
    logic          mv [2];
    logic [DW-1:0] md [2];
    int            last;
    logic [AW-1:0] maddr, eaddr;
    logic [1:0]    el, g;
    logic [1:0]    req, rdy;
    logic [AW-1:0] ad [2];
    logic          ebusy;
    for (int i = 0; i < int'(IMG); i++) shadow[i] = init_val(i);
    shadow[5] = 8'hA5;
    cyc = 0;
    forever begin
      @(negedge clock);
      req = {rd1_req, rd0_req};
      rdy = {rd1_rready, rd0_rready};
      ad[0] = rd0_addr;
      ad[1] = rd1_addr;
      g = '0;
      if (!rst_n) begin
        for (int n = 0; n < 2; n++) begin due[n] = -1; mv[n] = 1'b0; md[n] = '0; end
        last = 1;
        maddr = '0;
      end else begin
        for (int n = 0; n < 2; n++)
          el[n] = req[n] && (due[n] != cyc + 1) && (!mv[n] || rdy[n]);
        if (el == 2'b11) g[1 - last] = 1'b1;
        else             g = el;
      end
      eaddr = g[0] ? ad[0] : (g[1] ? ad[1] : maddr);
      ebusy = (due[0] >= 0) || (due[1] >= 0) || mv[0] || mv[1];

      check("gnt0", rd0_gnt, g[0]);
      check("gnt1", rd1_gnt, g[1]);
      check("rvalid0", rd0_rvalid, mv[0]);
      check("rvalid1", rd1_rvalid, mv[1]);
      check("rdata0", rd0_rdata, mv[0] ? md[0] : '0);
      check("rdata1", rd1_rdata, mv[1] ? md[1] : '0);
      check("busy", busy, ebusy);
      check("bram_rd_addr", bram_rd_addr, eaddr);
      check("wr_en", {wr_gnt, bram_wr_en}, {wr_req, wr_req});
      if (wr_req) check("wr_fwd", {bram_wr_addr, bram_wr_data}, {wr_addr, wr_data});

      if (rst_n) begin
        if (wr_req) shadow[wr_addr] = wr_data;
        for (int n = 0; n < 2; n++) begin
          if (due[n] == cyc + 1) begin
            mv[n] = 1'b1; md[n] = due_dat[n]; due[n] = -1;
          end else if (rdy[n]) begin
            mv[n] = 1'b0; md[n] = '0;
          end
          if (g[n]) begin
            due[n] = cyc + 2; due_dat[n] = shadow[ad[n]]; last = n;
          end
        end
        maddr = eaddr;
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state with requests present: no grants, everything cleared.
    repeat (3) step();
    rd0_req = 1'b1; rd1_req = 1'b1; rd0_addr = 5;
    #2;
    check("rst_gnt", {rd1_gnt, rd0_gnt}, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_rd_addr", bram_rd_addr, 0);
    check("rst_rvalid", {rd1_rvalid, rd0_rvalid}, 2'b00);

    // Single read of preloaded address 5.
    step(); rst_n = 1'b1; rd1_req = 1'b0;
    #2; check("s1_gnt0", rd0_gnt, 1); check("s1_addr", bram_rd_addr, 5);
    step(); rd0_req = 1'b0;
    #2; check("s1_busy_c1", busy, 1); check("s1_rvalid_c1", rd0_rvalid, 0);
    step();
    #2; check("s1_rvalid_c2", rd0_rvalid, 1); check("s1_rdata_c2", rd0_rdata, 8'hA5);
    step();
    #2; check("s1_rvalid_c3", rd0_rvalid, 0); check("s1_rdata_c3", rd0_rdata, 0);

    // Alternating grants from a fresh reset.
    step(); rst_n = 1'b0;
    step(); step(); rst_n = 1'b1;
    rd0_req = 1'b1; rd1_req = 1'b1; rd0_addr = 10; rd1_addr = 20;
    for (int k = 0; k < 6; k++) begin
      #2;
      check("s2_gnt0", rd0_gnt, (k % 2) == 0);
      check("s2_gnt1", rd1_gnt, (k % 2) == 1);
      step();
    end
    rd0_req = 1'b0; rd1_req = 1'b0;
    repeat (3) step();

    // rd1 stalls its response; rd0 continues every other cycle.
    rd0_req = 1'b1; rd1_req = 1'b1; rd1_rready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #2;
      check("s3_gnt0", rd0_gnt, (k % 2) == 0);
      check("s3_gnt1", rd1_gnt, k == 1);
      if (k >= 3) check("s3_hold1", {rd1_rvalid, rd1_rdata}, {1'b1, 8'h8F});
      step();
    end
    rd0_req = 1'b0; rd1_req = 1'b0; rd1_rready = 1'b1;
    repeat (3) step();

    // Same-cycle write and read of address 7.
    rd0_req = 1'b1; rd0_addr = 7; wr_req = 1'b1; wr_addr = 7; wr_data = 8'h3C;
    #2;
    check("s4_wr", {wr_gnt, bram_wr_en, bram_wr_addr}, {2'b11, 6'd7});
    check("s4_gnt0", rd0_gnt, 1);
    step(); rd0_req = 1'b0; wr_req = 1'b0;
    step();
    #2; check("s4_rdata", {rd0_rvalid, rd0_rdata}, {1'b1, 8'h3C});
    repeat (2) step();

    // Reset during the capture cycle of an outstanding read.
    rd0_req = 1'b1; rd0_addr = 3;
    #2; check("s5_gnt0", rd0_gnt, 1);
    step(); rd0_req = 1'b0; rst_n = 1'b0;
    #2; check("s5_busy_rst", busy, 0); check("s5_rvalid_rst", rd0_rvalid, 0);
    step(); step(); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2; check("s5_quiet", {busy, rd1_rvalid, rd0_rvalid}, 3'b000);
      step();
    end
    rd0_req = 1'b1; rd1_req = 1'b1; rd0_addr = 1; rd1_addr = 2;
    #2; check("s5_next_gnt", {rd1_gnt, rd0_gnt}, 2'b01);
    step(); rd0_req = 1'b0; rd1_req = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
